// File: rtl/booth2_mult_seq.sv
// Sequential radix-4 Booth 8x8 signed multiplier: one Booth digit per CALC cycle.
// Optional macro BOOTH2_SEQ_EARLY_EXIT_EN finishes once the remaining multiplier digits are all zero-valued.
module booth2_mult_seq (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  a_num,
    input  logic [7:0]  b_num,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] product,
    output logic        busy
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [7:0]  aReg_q, aReg_d;
    logic [7:0]  bReg_q, bReg_d;
    logic [15:0] acc_q, acc_d;
    logic [1:0]  cnt_q, cnt_d;

    logic [8:0]  bExt;
    logic [2:0]  code;
    logic [9:0]  aExt;
    logic [9:0]  multiple;
    logic [15:0] ppShift;
    logic        lastDigit;

    // Digit code with the implicit B[-1]=0 appended below the LSB.
    always_comb begin
        bExt = {bReg_q, 1'b0};
        case (cnt_q)
            2'd0:    code = bExt[2:0];
            2'd1:    code = bExt[4:2];
            2'd2:    code = bExt[6:4];
            default: code = bExt[8:6];
        endcase
    end

    // Ten bits so that -2 * (-128) = +256 stays representable.
    always_comb begin
        aExt = {{2{aReg_q[7]}}, aReg_q};
        case (code)
            3'b001, 3'b010: multiple = aExt;
            3'b011:         multiple = aExt << 1;
            3'b100:         multiple = -(aExt << 1);
            3'b101, 3'b110: multiple = -aExt;
            default:        multiple = 10'd0;
        endcase
        ppShift = {{6{multiple[9]}}, multiple} << {cnt_q, 1'b0};
    end

`ifdef BOOTH2_SEQ_EARLY_EXIT_EN
    logic signed [7:0] bUpper;

    // Uniform upper bits mean every remaining digit code is 000 or 111.
    always_comb begin
        bUpper    = $signed(bReg_q) >>> {cnt_q, 1'b1};
        lastDigit = (cnt_q == 2'd3) || (bUpper == 8'sd0) || (bUpper == -8'sd1);
    end
`else
    always_comb begin
        lastDigit = (cnt_q == 2'd3);
    end
`endif

    always_comb begin
        state_d = state_q;
        aReg_d  = aReg_q;
        bReg_d  = bReg_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    aReg_d  = a_num;
                    bReg_d  = b_num;
                    acc_d   = 16'd0;
                    cnt_d   = 2'd0;
                    state_d = ST_CALC;
                end
            end
            ST_CALC: begin
                acc_d = acc_q + ppShift;
                cnt_d = cnt_q + 2'd1;
                if (lastDigit) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= ST_IDLE;
            aReg_q  <= 8'd0;
            bReg_q  <= 8'd0;
            acc_q   <= 16'd0;
            cnt_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            aReg_q  <= aReg_d;
            bReg_q  <= bReg_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q == ST_CALC) || (state_q == ST_DONE);
    assign product   = acc_q;

endmodule

// File: tb/tb_booth2_mult_seq.sv
// Randomized self-checking bench for booth2_mult_seq against a plain signed-multiply model.
// Latency expectation follows BOOTH2_SEQ_EARLY_EXIT_EN when the macro is defined.
module tb_booth2_mult_seq;

    logic        clock;
    logic        sysRstN;
    logic        inValid;
    logic        inReady;
    logic [7:0]  aNum;
    logic [7:0]  bNum;
    logic        outValid;
    logic        outReady;
    logic [15:0] product;
    logic        busy;

    int numChecks = 0;
    int numErrors = 0;

    booth2_mult_seq dut (
        .sys_clk   (clock),
        .sys_rst_n (sysRstN),
        .in_valid  (inValid),
        .in_ready  (inReady),
        .a_num     (aNum),
        .b_num     (bNum),
        .out_valid (outValid),
        .out_ready (outReady),
        .product   (product),
        .busy      (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        numChecks++;
        if (actual !== expected) begin
            numErrors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    function automatic logic [15:0] refProduct(input logic signed [7:0] a, input logic signed [7:0] b);
        int p;
        p = int'(a) * int'(b);
        return p[15:0];
    endfunction

    // Early exit: the digit count is the smallest 2n-bit signed width that holds b.
    function automatic int refLatency(input logic signed [7:0] b);
`ifdef BOOTH2_SEQ_EARLY_EXIT_EN
        int bi;
        int lim;
        bi = int'(b);
        for (int n = 1; n <= 4; n++) begin
            lim = 1 << (2 * n - 1);
            if (bi >= -lim && bi < lim) return n;
        end
        return 4;
`else
        return 4;
`endif
    endfunction

    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input int stall);
        logic [15:0] expProd;
        int lat;
        expProd = refProduct(a, b);
        @(negedge clock);
        outReady = 1'b0;
        checkOutput("idle_in_ready", 32'(inReady), 32'd1);
        aNum    = a;
        bNum    = b;
        inValid = 1'b1;
        lat = 0;
        do begin
            @(negedge clock);
            if (lat == 0) checkOutput("calc_busy", 32'(busy), 32'd1);
            lat++;
            inValid = 1'($urandom_range(0, 1));
            aNum    = 8'($urandom);
            bNum    = 8'($urandom);
        end while (!outValid && lat < 12);
        // first iteration only covers the accept edge
        checkOutput("latency", 32'(lat - 1), 32'(refLatency(b)));
        checkOutput("product", 32'(product), 32'(expProd));
        checkOutput("done_in_ready", 32'(inReady), 32'd0);
        for (int i = 0; i < stall; i++) begin
            inValid = 1'b1;
            @(negedge clock);
            checkOutput("stall_valid", 32'(outValid), 32'd1);
            checkOutput("stall_product", 32'(product), 32'(expProd));
        end
        inValid  = 1'b0;
        outReady = 1'b1;
        @(negedge clock);
        outReady = 1'($urandom_range(0, 1));
        checkOutput("post_valid", 32'(outValid), 32'd0);
        checkOutput("post_in_ready", 32'(inReady), 32'd1);
        checkOutput("post_hold", 32'(product), 32'(expProd));
    endtask

    initial begin
        sysRstN  = 1'b0;
        inValid  = 1'b0;
        outReady = 1'b0;
        aNum     = 8'd0;
        bNum     = 8'd0;
        #12;
        checkOutput("rst_in_ready", 32'(inReady), 32'd1);
        checkOutput("rst_out_valid", 32'(outValid), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_product", 32'(product), 32'd0);
        @(negedge clock);
        sysRstN = 1'b1;

        applyStimulus(8'd7, 8'hFD, 0);
        applyStimulus(8'h80, 8'h80, 1);
        applyStimulus(8'h80, 8'd127, 0);
        applyStimulus(8'd127, 8'd127, 2);
        applyStimulus(8'd25, 8'd10, 10);
        applyStimulus(8'd100, 8'd1, 0);
        applyStimulus(8'd100, 8'd4, 0);
        applyStimulus(8'd100, 8'h80, 0);
        applyStimulus(8'd55, 8'd0, 0);
        applyStimulus(8'hC3, 8'hFF, 0);

        // Reset during the second CALC cycle must clear everything at once.
        @(negedge clock);
        aNum    = 8'd25;
        bNum    = 8'd10;
        inValid = 1'b1;
        @(negedge clock);
        inValid = 1'b0;
        @(negedge clock);
        sysRstN = 1'b0;
        #1;
        checkOutput("midrst_out_valid", 32'(outValid), 32'd0);
        checkOutput("midrst_in_ready", 32'(inReady), 32'd1);
        checkOutput("midrst_product", 32'(product), 32'd0);
        checkOutput("midrst_busy", 32'(busy), 32'd0);
        @(negedge clock);
        sysRstN = 1'b1;
        applyStimulus(8'd3, 8'd5, 0);

        for (int i = 0; i < 400; i++) begin
            applyStimulus(8'($urandom), 8'($urandom), int'($urandom_range(0, 3)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", numChecks, numErrors);
        $finish;
    end

endmodule
